// File: rtl/param_register_pkg.sv
// Shared constants and helpers for the parametrised register block.
// Helpers operate on maximum-size vectors so they serve any legal configuration.
package param_register_pkg;

    localparam int unsigned REG_NUM_W  = 32;
    localparam int unsigned MAX_REGS   = 256;
    localparam int unsigned MAX_DATA_W = 32;
    localparam int unsigned MAX_PACK_W = MAX_REGS * MAX_DATA_W;

    function automatic logic reg_is_ro(input logic [MAX_REGS-1:0] mask, input int unsigned idx);
        logic ro;
        ro = 1'b0;
        if (idx < MAX_REGS) begin
            ro = mask[8'(idx)];
        end
        return ro;
    endfunction

    // Places one register's reset value into its slot; OR results together for RESET_VALS.
    function automatic logic [MAX_PACK_W-1:0] pack_reg_val(input logic [MAX_DATA_W-1:0] val,
                                                           input int unsigned idx,
                                                           input int unsigned width);
        logic [MAX_DATA_W-1:0] mask;
        logic [MAX_PACK_W-1:0] packed_val;
        mask = (width >= MAX_DATA_W) ? '1 : ((32'd1 << width) - 32'd1);
        packed_val = MAX_PACK_W'(val & mask) << (idx * width);
        return packed_val;
    endfunction

endpackage

// File: rtl/param_register_cell.sv
// One read/write register with its reset value and a write strobe aligned
// with the value update.
module param_register_cell #(
    parameter int unsigned     DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q,
    output logic              strobe
);

    logic [DATA_W-1:0] value_q, value_d;
    logic              strobe_q, strobe_d;

    always_comb begin
        value_d  = value_q;
        strobe_d = we;
        if (we) begin
            value_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q  <= RESET_VAL;
            strobe_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            strobe_q <= strobe_d;
        end
    end

    assign q      = value_q;
    assign strobe = strobe_q;

endmodule

// File: rtl/param_register_block.sv
// Select-then-access register file: register-number latch with optional
// post-increment, read mux, sticky error flags and per-register write strobes.
module param_register_block
    import param_register_pkg::*;
#(
    parameter int unsigned                   NUM_REGS   = 32,
    parameter int unsigned                   DATA_W     = 32,
    parameter int unsigned                   ADDR_W     = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0]           RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]    RESET_VALS = '0,
    parameter bit                            AUTO_INC   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                rx_data,
    input  logic                       reg_num_le,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [31:0]                tx_data,
    output logic                       rd_valid,
    output logic                       illegal_reg_num,
    output logic                       err_illegal,
    output logic                       err_ro_write,
    input  logic                       err_clr,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_strobe,
    input  logic [NUM_REGS*DATA_W-1:0] ro_data
);

    localparam logic [REG_NUM_W-1:0] NUM_REGS_N = REG_NUM_W'(NUM_REGS);
    localparam logic [REG_NUM_W-1:0] LAST_NUM   = REG_NUM_W'(NUM_REGS - 1);
    localparam logic [REG_NUM_W-1:0] ONE        = REG_NUM_W'(1);

    logic [REG_NUM_W-1:0] reg_num_q, reg_num_d;
    logic [31:0]          tx_data_q, tx_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 err_illegal_q, err_illegal_d;
    logic                 err_ro_write_q, err_ro_write_d;

    logic [ADDR_W-1:0]    idx;
    logic [DATA_W-1:0]    rd_word;
    logic                 sel_ro;
    logic                 access;
    logic                 wr_act;
    logic [NUM_REGS-1:0]  cell_we;

    assign illegal_reg_num = (reg_num_q >= NUM_REGS_N);
    assign idx             = reg_num_q[ADDR_W-1:0];

    // Read mux sees the registered cell values, so a same-cycle write returns the old data.
    always_comb begin
        rd_word = '0;
        sel_ro  = 1'b0;
        cell_we = '0;
        access  = !reg_num_le && (rd_en || wr_en);
        wr_act  = !reg_num_le && wr_en && !illegal_reg_num;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == ADDR_W'(i)) begin
                sel_ro  = RO_MASK[i];
                rd_word = RO_MASK[i] ? ro_data[i*DATA_W +: DATA_W] : reg_q[i*DATA_W +: DATA_W];
                cell_we[i] = wr_act && !RO_MASK[i];
            end
        end
    end

    always_comb begin
        reg_num_d      = reg_num_q;
        tx_data_d      = tx_data_q;
        rd_valid_d     = !reg_num_le && rd_en;
        err_illegal_d  = err_illegal_q && !err_clr;
        err_ro_write_d = err_ro_write_q && !err_clr;

        if (reg_num_le) begin
            reg_num_d = rx_data;
        end else if (AUTO_INC && access) begin
            // Legal numbers wrap within the file; illegal ones roll over only at 2^32.
            if (!illegal_reg_num && (reg_num_q == LAST_NUM)) begin
                reg_num_d = '0;
            end else begin
                reg_num_d = reg_num_q + ONE;
            end
        end

        if (!reg_num_le && rd_en) begin
            tx_data_d = illegal_reg_num ? '0 : 32'(rd_word);
        end

        if (access && illegal_reg_num) begin
            err_illegal_d = 1'b1;
        end
        if (wr_act && sel_ro) begin
            err_ro_write_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reg_num_q      <= '0;
            tx_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_ro_write_q <= 1'b0;
        end else begin
            reg_num_q      <= reg_num_d;
            tx_data_q      <= tx_data_d;
            rd_valid_q     <= rd_valid_d;
            err_illegal_q  <= err_illegal_d;
            err_ro_write_q <= err_ro_write_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (reg_is_ro(MAX_REGS'(RO_MASK), gi)) begin : g_ro
            assign reg_q[gi*DATA_W +: DATA_W] = '0;
            assign wr_strobe[gi]              = 1'b0;
        end else begin : g_rw
            param_register_cell #(
                .DATA_W    (DATA_W),
                .RESET_VAL (RESET_VALS[gi*DATA_W +: DATA_W])
            ) u_cell (
                .clk     (clk),
                .reset_n (reset_n),
                .we      (cell_we[gi]),
                .wdata   (rx_data[DATA_W-1:0]),
                .q       (reg_q[gi*DATA_W +: DATA_W]),
                .strobe  (wr_strobe[gi])
            );
        end
    end

    assign tx_data      = tx_data_q;
    assign rd_valid     = rd_valid_q;
    assign err_illegal  = err_illegal_q;
    assign err_ro_write = err_ro_write_q;

endmodule

// File: tb/tb_param_register_block.sv
// Directed bench for param_register_block: 8 x 16-bit registers, register 7
// read-only, register 2 resetting to 7000.
module tb_param_register_block;
    import param_register_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 16;
    localparam logic [N-1:0]      RO = 8'b1000_0000;
    localparam logic [N*DW-1:0]   RV = 128'(pack_reg_val(32'd7000, 2, 16));

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   rx_data;
    logic          reg_num_le, wr_en, rd_en, err_clr;
    logic [31:0]   tx_data;
    logic          rd_valid, illegal_reg_num, err_illegal, err_ro_write;
    logic [N*DW-1:0] reg_q;
    logic [N-1:0]  wr_strobe;
    logic [N*DW-1:0] ro_data;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [DW-1:0] exp_r [N];

    param_register_block #(
        .NUM_REGS   (N),
        .DATA_W     (DW),
        .RO_MASK    (RO),
        .RESET_VALS (RV),
        .AUTO_INC   (1'b1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx_data         (rx_data),
        .reg_num_le      (reg_num_le),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .tx_data         (tx_data),
        .rd_valid        (rd_valid),
        .illegal_reg_num (illegal_reg_num),
        .err_illegal     (err_illegal),
        .err_ro_write    (err_ro_write),
        .err_clr         (err_clr),
        .reg_q           (reg_q),
        .wr_strobe       (wr_strobe),
        .ro_data         (ro_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [N*DW-1:0] exp_pack();
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i != 7) v[i*DW +: DW] = exp_r[i];
        end
        return v;
    endfunction

    task automatic exp_reset();
        for (int i = 0; i < N; i++) exp_r[i] = '0;
        exp_r[2] = 16'd7000;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input logic [31:0] n);
        rx_data = n; reg_num_le = 1'b1;
        cyc();
        reg_num_le = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        rx_data = d; wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(); cyc();
        exp_reset();
        checks++; if (reg_q !== exp_pack()) begin errors++; $display("FAIL reset_reg_q: got %h want %h", reg_q, exp_pack()); end
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx: got %h want 0", tx_data); end
        checks++; if ({rd_valid, wr_strobe, err_illegal, err_ro_write, illegal_reg_num} !== 12'h0) begin
            errors++; $display("FAIL reset_flags: got %b want 0", {rd_valid, wr_strobe, err_illegal, err_ro_write, illegal_reg_num}); end
        reset_n = 1'b1;
        sel(32'd2);
        rd();
        checks++; if (tx_data !== 32'h0000_1B58) begin errors++; $display("FAIL read_reset_val: got %h want 00001b58", tx_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_pulse: got %b want 1", rd_valid); end
        cyc();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid); end
        checks++; if ({err_illegal, err_ro_write} !== 2'b00) begin errors++; $display("FAIL read_errs: got %b want 00", {err_illegal, err_ro_write}); end
    endtask

    task automatic test_auto_inc();
        sel(32'd6);
        wr(32'h0000_AAAA);
        exp_r[6] = 16'hAAAA;
        checks++; if (wr_strobe !== 8'h40) begin errors++; $display("FAIL burst_strobe6: got %h want 40", wr_strobe); end
        checks++; if (reg_q !== exp_pack()) begin errors++; $display("FAIL burst_reg6: got %h want %h", reg_q, exp_pack()); end
        wr(32'h0000_5555);
        checks++; if (wr_strobe !== 8'h00) begin errors++; $display("FAIL burst_ro_strobe: got %h want 00", wr_strobe); end
        checks++; if (reg_q !== exp_pack()) begin errors++; $display("FAIL burst_reg7: got %h want %h", reg_q, exp_pack()); end
        checks++; if (err_ro_write !== 1'b1) begin errors++; $display("FAIL burst_err_ro: got %b want 1", err_ro_write); end
        checks++; if (dut.reg_num_q !== 32'd0) begin errors++; $display("FAIL burst_wrap: got %0d want 0", dut.reg_num_q); end
    endtask

    task automatic test_ro();
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        checks++; if (err_ro_write !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err_ro_write); end
        ro_data = '0;
        ro_data[7*DW +: DW] = 16'h1234;
        sel(32'd7);
        rd();
        checks++; if (tx_data !== 32'h0000_1234) begin errors++; $display("FAIL ro_read: got %h want 00001234", tx_data); end
        sel(32'd7);
        wr(32'h0000_FFFF);
        checks++; if (wr_strobe !== 8'h00) begin errors++; $display("FAIL ro_write_strobe: got %h want 00", wr_strobe); end
        checks++; if (err_ro_write !== 1'b1) begin errors++; $display("FAIL ro_write_err: got %b want 1", err_ro_write); end
        checks++; if (reg_q !== exp_pack()) begin errors++; $display("FAIL ro_write_regs: got %h want %h", reg_q, exp_pack()); end
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        checks++; if (err_ro_write !== 1'b0) begin errors++; $display("FAIL ro_err_clr: got %b want 0", err_ro_write); end
        sel(32'd7);
        err_clr = 1'b1; wr(32'h0000_0001); err_clr = 1'b0;
        checks++; if (err_ro_write !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", err_ro_write); end
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
    endtask

    task automatic test_illegal();
        sel(32'd9);
        checks++; if (illegal_reg_num !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", illegal_reg_num); end
        rd();
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL illegal_read: got %h want 0", tx_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL illegal_rd_valid: got %b want 1", rd_valid); end
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", err_illegal); end
        wr(32'h0000_9999);
        checks++; if (reg_q !== exp_pack() || wr_strobe !== 8'h00) begin errors++; $display("FAIL illegal_write: got %h/%h want %h/00", reg_q, wr_strobe, exp_pack()); end
        checks++; if (err_ro_write !== 1'b0) begin errors++; $display("FAIL illegal_no_ro_err: got %b want 0", err_ro_write); end
        checks++; if (dut.reg_num_q !== 32'd11) begin errors++; $display("FAIL illegal_inc: got %0d want 11", dut.reg_num_q); end
        sel(32'hFFFF_FFFF);
        rd();
        checks++; if (illegal_reg_num !== 1'b0 || dut.reg_num_q !== 32'd0) begin
            errors++; $display("FAIL max_rollover: got %0d/%b want 0/0", dut.reg_num_q, illegal_reg_num); end
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_clr: got %b want 0", err_illegal); end
    endtask

    task automatic test_le_priority();
        sel(32'd5);
        rx_data = 32'd3; reg_num_le = 1'b1; wr_en = 1'b1;
        cyc();
        reg_num_le = 1'b0; wr_en = 1'b0;
        checks++; if (reg_q !== exp_pack() || wr_strobe !== 8'h00) begin errors++; $display("FAIL le_wr_ignored: got %h/%h want %h/00", reg_q, wr_strobe, exp_pack()); end
        checks++; if (dut.reg_num_q !== 32'd3) begin errors++; $display("FAIL le_wr_num: got %0d want 3", dut.reg_num_q); end
        rx_data = 32'd4; reg_num_le = 1'b1; rd_en = 1'b1;
        cyc();
        reg_num_le = 1'b0; rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0 || dut.reg_num_q !== 32'd4) begin errors++; $display("FAIL le_rd_ignored: got %b/%0d want 0/4", rd_valid, dut.reg_num_q); end
        checks++; if ({err_illegal, err_ro_write} !== 2'b00) begin errors++; $display("FAIL le_no_err: got %b want 00", {err_illegal, err_ro_write}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        sel(32'd0);
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = {16'h0, vals[i]};
            cyc();
            exp_r[i] = vals[i];
            checks++; if (wr_strobe !== (8'h01 << i) || reg_q !== exp_pack()) begin
                errors++; $display("FAIL b2b_write%0d: got %h/%h want %h/%h", i, wr_strobe, reg_q, 8'h01 << i, exp_pack()); end
        end
        wr_en = 1'b0;
        sel(32'd1);
        rx_data = 32'h0000_BEEF; rd_en = 1'b1; wr_en = 1'b1;
        cyc();
        rd_en = 1'b0; wr_en = 1'b0;
        exp_r[1] = 16'hBEEF;
        checks++; if (tx_data !== 32'h0000_2222 || rd_valid !== 1'b1) begin errors++; $display("FAIL rw_old_data: got %h/%b want 00002222/1", tx_data, rd_valid); end
        checks++; if (reg_q !== exp_pack() || wr_strobe !== 8'h02) begin errors++; $display("FAIL rw_write: got %h/%h want %h/02", reg_q, wr_strobe, exp_pack()); end
        checks++; if (dut.reg_num_q !== 32'd2) begin errors++; $display("FAIL rw_single_inc: got %0d want 2", dut.reg_num_q); end
    endtask

    task automatic test_burst_interrupt();
        sel(32'd4);
        wr_en = 1'b1; rx_data = 32'h0000_0A0A;
        cyc();
        exp_r[4] = 16'h0A0A;
        checks++; if (wr_strobe !== 8'h10 || reg_q !== exp_pack()) begin errors++; $display("FAIL int_first: got %h/%h want 10/%h", wr_strobe, reg_q, exp_pack()); end
        reg_num_le = 1'b1; rx_data = 32'd1;
        cyc();
        reg_num_le = 1'b0;
        checks++; if (wr_strobe !== 8'h00 || reg_q !== exp_pack() || dut.reg_num_q !== 32'd1) begin
            errors++; $display("FAIL int_le: got %h/%0d want 00/1", wr_strobe, dut.reg_num_q); end
        rx_data = 32'h0000_0B0B;
        cyc();
        exp_r[1] = 16'h0B0B;
        checks++; if (wr_strobe !== 8'h02 || reg_q !== exp_pack()) begin errors++; $display("FAIL int_resume: got %h/%h want 02/%h", wr_strobe, reg_q, exp_pack()); end
        reset_n = 1'b0; rx_data = 32'h0000_0C0C;
        cyc();
        reset_n = 1'b1; wr_en = 1'b0;
        exp_reset();
        checks++; if (reg_q !== exp_pack() || wr_strobe !== 8'h00) begin errors++; $display("FAIL int_reset_regs: got %h/%h want %h/00", reg_q, wr_strobe, exp_pack()); end
        checks++; if (dut.reg_num_q !== 32'd0 || tx_data !== 32'h0) begin errors++; $display("FAIL int_reset_num: got %0d/%h want 0/0", dut.reg_num_q, tx_data); end
    endtask

    initial begin
        reset_n = 1'b0; rx_data = '0; reg_num_le = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        err_clr = 1'b0; ro_data = '0;
        test_reset();
        test_auto_inc();
        test_ro();
        test_illegal();
        test_le_priority();
        test_back_to_back();
        test_burst_interrupt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_register_block.md
# param_register_block

Parametrised register file between the Master FPGA serial link and the channel datapath: N registers of configurable width, each either read/write or hardware-driven read-only. It keeps the select-then-access protocol (latch a register number, then read or write it), and adds auto-increment burst access, per-register write strobes, sticky error flags and a qualified read-data handshake. It replaces fixed 32-entry register blocks in new channel designs.

## Interface
- NUM_REGS, 32: number of registers, 2..256.
- DATA_W, 32: register width, 8..32.
- ADDR_W, $clog2(NUM_REGS): internal index width.
- RO_MASK, {NUM_REGS{1'b0}}: bit i = 1 means register i is read-only and reads from ro_data.
- RESET_VALS, all zero: packed NUM_REGS×DATA_W reset values for RW registers.
- AUTO_INC, 1: 1 enables the register-number post-increment after each access.
- clk  in  1  interconnect clock.
- reset_n  in  1  synchronous, active-low reset.
- rx_data  in  32  register number (with reg_num_le) or write data (with wr_en).
- reg_num_le  in  1  latch rx_data as the selected register number.
- wr_en  in  1  write rx_data[DATA_W-1:0] to the selected register.
- rd_en  in  1  read the selected register.
- tx_data  out  32  read data, zero-extended; held between reads.
- rd_valid  out  1  one-cycle pulse, tx_data updated.
- illegal_reg_num  out  1  combinational; selected number ≥ NUM_REGS.
- err_illegal  out  1  sticky; a read or write was attempted while illegal_reg_num was high.
- err_ro_write  out  1  sticky; a write targeted a read-only register.
- err_clr  in  1  clears both sticky errors.
- reg_q  out  NUM_REGS×DATA_W  packed current register values (RO slots read as 0).
- wr_strobe  out  NUM_REGS  one-cycle pulse per written RW register, aligned with reg_q update.
- ro_data  in  NUM_REGS×DATA_W  packed hardware values for RO registers.

## Operation
- Register-number latch:
  - reg_num is a full 32-bit value; illegal_reg_num = (reg_num ≥ NUM_REGS).
  - reg_num_le has priority over rd_en and wr_en. Any rd_en or wr_en in the same cycle is ignored and flags nothing.
- Write (wr_en, legal number, RW register): the register is updated the next edge, and wr_strobe[i] pulses in that same cycle.
- Write to an RO register: no state change and no strobe; err_ro_write is set.
- Read (rd_en, legal number): on the next edge tx_data = register value (RW) or ro_data slot (RO), zero-extended, and rd_valid pulses.
- Simultaneous rd_en and wr_en: the write is performed, and the read returns the pre-write value.
- Illegal number:
  - Reads and writes change no register.
  - A read returns tx_data = 0 with rd_valid still pulsed, so the link never stalls.
  - err_illegal is set.
- Auto-increment (AUTO_INC=1):
  - After any rd_en or wr_en access, legal or not, reg_num increments by one; a simultaneous read and write count as one access.
  - Legal numbers wrap NUM_REGS-1 → 0.
  - Illegal numbers increment without wrapping, except 32'hFFFFFFFF → 0.
- Sticky errors: if err_clr and a new error occur in the same cycle, the set wins.
- Reset (reset_n low at an edge):
  - reg_num = 0, RW registers = RESET_VALS, tx_data = 0.
  - rd_valid, wr_strobe, err_illegal and err_ro_write = 0.
  - Any access pending in that cycle is discarded.

## Timing
- Write to reg_q: 1 cycle. Read to tx_data/rd_valid: 1 cycle.
- Back-to-back accesses are accepted every cycle, with no backpressure.
- illegal_reg_num is the only combinational output; all others are registered.
- A new reg_num is effective for an access issued in the following cycle.

## Structure
- Package param_register_pkg holds:
  - function reg_is_ro(mask, idx);
  - a packing helper for RESET_VALS;
  - the constant REG_NUM_W = 32.
- Sub-module param_register_cell holds one register with reset value, write enable and strobe, generated NUM_REGS times (RO slots are not instantiated).
- Top level contains the number latch, the incrementer, the read mux and the error flags.

## Test plan
Configuration for all scenarios: NUM_REGS=8, DATA_W=16, RO_MASK=8'b1000_0000, RESET_VALS[2]=16'd7000.
1. Reset, then select 2 and read → tx_data=0x00001B58 with one rd_valid pulse; err flags 0.
2. AUTO_INC: select 6, write 0xAAAA then 0x5555 → reg6=0xAAAA, reg7 unchanged, err_ro_write=1, reg_num=0.
3. ro_data[7]=0x1234, select 7, read → tx_data=0x00001234; write 0xFFFF → no strobe, err_ro_write=1; err_clr → 0.
4. Select 9 → illegal_reg_num=1; read → tx_data=0 with rd_valid pulsed, err_illegal=1; write → no reg_q change.
5. Same-cycle reg_num_le=3 and wr_en with rx_data=3 → reg3 unchanged, no strobe, reg_num=3.
6. reg_num_le during an active burst write, and reset_n low mid-burst → burst stops; all registers return to RESET_VALS and reg_num=0.
